// File: rtl/and2_gate_if.sv
// ----------------------------------------------------------------------------
// and2_gate_if : operand/result bundle for the and2_gate primitive
// Revision     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface and2_gate_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_rise;
    logic [WIDTH-1:0] out_fall;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output a,
        output b,
        input  out,
        input  out_q,
        input  out_rise,
        input  out_fall,
        input  hi_cnt
    );

    modport slave (
        input  a,
        input  b,
        output out,
        output out_q,
        output out_rise,
        output out_fall,
        output hi_cnt
    );
endinterface

`default_nettype wire

// File: rtl/and2_gate.sv
// ----------------------------------------------------------------------------
// and2_gate : bitwise AND with registered copy, edge pulses and high counter
//             (counter present only when AND2_STATS_EN is defined)
// Revision  : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module and2_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    and2_gate_if.slave   bus
);
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    assign w_and    = bus.a & bus.b;
    assign bus.out  = w_and;
    assign bus.out_q    = r_q;
    assign bus.out_rise = r_rise;
    assign bus.out_fall = r_fall;

    // Pulses compare the incoming value against the current out_q so they
    // appear in the same cycle out_q first shows the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_q    <= w_and;
            r_rise <= w_and & ~r_q;
            r_fall <= ~w_and & r_q;
        end
    end

`ifdef AND2_STATS_EN
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    logic [CNT_W-1:0] r_cnt;

    // Counts on the pre-update out_q[0]; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_q[0] && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.hi_cnt = r_cnt;
`else
    localparam logic [CNT_W-1:0] c_cnt_zero = {CNT_W{1'b0}};

    assign bus.hi_cnt = c_cnt_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_and2_gate.sv
// ----------------------------------------------------------------------------
// tb_and2_gate : directed self-checking bench for and2_gate (WIDTH 1 and 4)
// Revision     : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_and2_gate;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    and2_gate_if #(.WIDTH(1), .CNT_W(4)) bus1 ();
    and2_gate_if #(.WIDTH(4), .CNT_W(4)) bus4 ();

    and2_gate #(.WIDTH(1), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    and2_gate #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic test_reset;
        rst_n  = 1'b0;
        bus1.a = 1'b1;
        bus1.b = 1'b1;
        bus4.a = 4'b1111;
        bus4.b = 4'b1111;
        #3;
        total++; if (bus1.out !== 1'b1) begin bad++; $display("FAIL reset_out got=%b exp=1", bus1.out); end
        total++; if (bus1.out_q !== 1'b0) begin bad++; $display("FAIL reset_out_q got=%b exp=0", bus1.out_q); end
        total++; if (bus1.out_rise !== 1'b0) begin bad++; $display("FAIL reset_rise got=%b exp=0", bus1.out_rise); end
        total++; if (bus1.out_fall !== 1'b0) begin bad++; $display("FAIL reset_fall got=%b exp=0", bus1.out_fall); end
        total++; if (bus1.hi_cnt !== 4'd0) begin bad++; $display("FAIL reset_hi_cnt got=%0d exp=0", bus1.hi_cnt); end
        total++; if (bus4.out !== 4'b1111) begin bad++; $display("FAIL reset_out4 got=%b exp=1111", bus4.out); end
        total++; if (bus4.out_q !== 4'b0000) begin bad++; $display("FAIL reset_out_q4 got=%b exp=0000", bus4.out_q); end
    endtask

    task automatic test_truth_table;
        logic [1:0] va [5];
        logic [1:0] vb [5];
        logic       ve [5];
        va = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        vb = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        ve = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus1.a = va[i][0];
            bus1.b = vb[i][0];
            #1;
            total++;
            if (bus1.out !== ve[i]) begin
                bad++;
                $display("FAIL truth_%0d a=%b b=%b got=%b exp=%b", i, bus1.a, bus1.b, bus1.out, ve[i]);
            end
            #9;
        end
    endtask

    task automatic test_latency;
        bus4.a = 4'b0000;
        bus4.b = 4'b0000;
        @(negedge clk);
        rst_n  = 1'b1;
        bus1.a = 1'b1;
        bus1.b = 1'b1;
        @(posedge clk); #1;
        total++; if (bus1.out_q !== 1'b1) begin bad++; $display("FAIL lat_out_q got=%b exp=1", bus1.out_q); end
        total++; if (bus1.out_rise !== 1'b1) begin bad++; $display("FAIL lat_rise got=%b exp=1", bus1.out_rise); end
        total++; if (bus1.out_fall !== 1'b0) begin bad++; $display("FAIL lat_fall got=%b exp=0", bus1.out_fall); end
        @(posedge clk); #1;
        total++; if (bus1.out_q !== 1'b1) begin bad++; $display("FAIL hold_out_q got=%b exp=1", bus1.out_q); end
        total++; if (bus1.out_rise !== 1'b0) begin bad++; $display("FAIL hold_rise got=%b exp=0", bus1.out_rise); end
    endtask

    task automatic test_fall;
        @(negedge clk);
        bus1.b = 1'b0;
        @(posedge clk); #1;
        total++; if (bus1.out_q !== 1'b0) begin bad++; $display("FAIL fall_out_q got=%b exp=0", bus1.out_q); end
        total++; if (bus1.out_fall !== 1'b1) begin bad++; $display("FAIL fall_pulse got=%b exp=1", bus1.out_fall); end
        total++; if (bus1.out_rise !== 1'b0) begin bad++; $display("FAIL fall_rise got=%b exp=0", bus1.out_rise); end
        @(posedge clk); #1;
        total++; if (bus1.out_fall !== 1'b0) begin bad++; $display("FAIL fall_end got=%b exp=0", bus1.out_fall); end
    endtask

    task automatic test_counter;
        logic [3:0] exp;
        rst_n = 1'b0;
        #1;
        total++; if (bus1.hi_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clear got=%0d exp=0", bus1.hi_cnt); end
        @(negedge clk);
        rst_n  = 1'b1;
        bus1.a = 1'b1;
        bus1.b = 1'b1;
        // Edge 1 loads out_q=1; counting starts from edge 2.
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
`ifdef AND2_STATS_EN
            exp = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
`else
            exp = 4'd0;
`endif
            total++;
            if (bus1.hi_cnt !== exp) begin
                bad++;
                $display("FAIL cnt_edge_%0d got=%0d exp=%0d", k, bus1.hi_cnt, exp);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus1.hi_cnt !== 4'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", bus1.hi_cnt); end
        total++; if (bus1.out_q !== 1'b0) begin bad++; $display("FAIL midrst_out_q got=%b exp=0", bus1.out_q); end
        total++; if (bus1.out !== 1'b1) begin bad++; $display("FAIL midrst_out got=%b exp=1", bus1.out); end
    endtask

    task automatic test_bitwise;
        bus4.a = 4'b1100;
        bus4.b = 4'b1010;
        #1;
        total++; if (bus4.out !== 4'b1000) begin bad++; $display("FAIL bw_out got=%b exp=1000", bus4.out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus4.out_q !== 4'b1000) begin bad++; $display("FAIL bw_out_q got=%b exp=1000", bus4.out_q); end
        total++; if (bus4.out_rise !== 4'b1000) begin bad++; $display("FAIL bw_rise got=%b exp=1000", bus4.out_rise); end
        total++; if (bus4.out_fall !== 4'b0000) begin bad++; $display("FAIL bw_fall got=%b exp=0000", bus4.out_fall); end
        @(negedge clk);
        bus4.a = 4'b0110;
        bus4.b = 4'b0111;
        @(posedge clk); #1;
        total++; if (bus4.out_q !== 4'b0110) begin bad++; $display("FAIL bw2_out_q got=%b exp=0110", bus4.out_q); end
        total++; if (bus4.out_rise !== 4'b0110) begin bad++; $display("FAIL bw2_rise got=%b exp=0110", bus4.out_rise); end
        total++; if (bus4.out_fall !== 4'b1000) begin bad++; $display("FAIL bw2_fall got=%b exp=1000", bus4.out_fall); end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_latency();
        test_fall();
        test_counter();
        test_bitwise();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/and2_gate.md
Name: and2_gate

Overview:
- Two-input bitwise AND gate with a combinational result plus a registered copy and a small status layer.
- Leaf logic primitive used wherever a gated enable or qualify function is needed.
- The combinational path gives zero-latency gating.
- The registered path and status outputs give glitch-free, clock-aligned versions for downstream synchronous logic.

Parameters:
- WIDTH, 1, bit width of a, b and all data outputs; bitwise AND per bit.
- CNT_W, 16, width of the high-cycle counter (only used when AND2_STATS_EN is defined).

Ports:
- clk  input  1  system clock, rising edge active.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out  output  WIDTH  combinational a & b.
- out_q  output  WIDTH  registered a & b.
- out_rise  output  WIDTH  one-cycle pulse per bit when out_q goes 0->1.
- out_fall  output  WIDTH  one-cycle pulse per bit when out_q goes 1->0.
- hi_cnt  output  CNT_W  number of clock cycles in which bit 0 of out_q was 1.

Behaviour:
- Reset and clock/reset requirements:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n low immediately forces out_q, out_rise, out_fall and hi_cnt to 0, with no clock needed.
  - Release of rst_n is synchronous in effect: the first update happens on the first rising clk edge with rst_n high.
- Combinational output:
  - out = a & b at all times, including during reset.
  - Purely combinational, zero latency, no dependence on clk or rst_n.
- Truth table per bit: 00->0, 01->0, 10->0, 11->1.
- X handling: standard Verilog & semantics (0 & X = 0, 1 & X = X). No X masking.
- Registered output:
  - out_q <= a & b on each rising clk edge.
  - Latency is 1 cycle relative to a/b sampled at the edge.
- Edge pulses:
  - out_rise and out_fall are registered.
  - out_rise[i] = 1 for exactly one cycle after the edge where out_q[i] changes 0->1.
  - out_fall[i] = 1 for exactly one cycle after the edge where out_q[i] changes 1->0.
  - In practice they are computed from the previous out_q and the new a & b at the same edge, so each pulse is coincident with the cycle in which out_q first shows the new value.
  - Both pulses are never high simultaneously on the same bit.
  - First edge after reset: previous out_q is taken as 0. If a & b = 1 at that edge, out_rise asserts.
- Counter (stats): hi_cnt increments by 1 on each rising edge at which out_q[0] is 1 (before update). It saturates at all-ones and never wraps.
- Reset mid-operation: all registers clear asynchronously and any in-progress pulse is dropped. out keeps tracking a & b.
- No state machine and no handshake. Inputs may change at any time; only values at rising clk edges affect registered outputs.

Optional Feature:
- Macro AND2_STATS_EN.
- When defined: hi_cnt counter implemented as above.
- When undefined: no counter register is synthesized and hi_cnt is driven constant 0. All other behaviour is unchanged.

Test Plan:
- Async reset: hold rst_n=0 with a=1, b=1 -> out=1 immediately; out_q=0, out_rise=0, out_fall=0, hi_cnt=0 with no clock edge.
- Truth-table sweep, WIDTH=1, inputs changed every 10 time units:
  - (a,b) = (0,0), (1,0), (0,1), (1,1), (0,0)
  - Required out = 0, 0, 0, 1, 0 respectively, settled within the same time step.
- Registered latency: after reset release, apply a=1, b=1 before an edge -> out_q=1 and out_rise=1 after that edge. On the next edge with inputs held, out_rise=0 and out_q stays 1.
- Falling pulse: from out_q=1 set b=0 -> after next edge out_q=0, out_fall=1 for one cycle, out_rise=0.
- Counter (AND2_STATS_EN defined, CNT_W=4):
  - Hold a=b=1 for 20 cycles -> hi_cnt climbs to 15 and stays 15, no wrap.
  - Assert rst_n=0 mid-run -> hi_cnt=0 at once.
- Bitwise WIDTH=4: a=4'b1100, b=4'b1010 -> out=4'b1000. After one edge, out_q=4'b1000 and out_rise=4'b1000.
